// File: rtl/cic_dec_ctrl_if.sv
// Decimation-change request channel between a requester and cic_dec_ctrl.
// A request transfers on a clock edge where cfg_valid && cfg_ready; the requester holds cfg_valid/cfg_dec stable until then.
interface cic_dec_ctrl_if #(
  parameter int DEC_WIDTH = 4
);
  logic                 cfg_valid;
  logic [DEC_WIDTH:0]   cfg_dec;
  logic                 cfg_ready;
  logic                 cfg_err;

  modport master (output cfg_valid, output cfg_dec, input cfg_ready, input cfg_err);
  modport slave  (input cfg_valid, input cfg_dec, output cfg_ready, output cfg_err);
endinterface

// File: rtl/cic_dec_ctrl.sv
// Run-time controller for the CIC decimator: drain, flush and settle on every decimation change.
// Optional statistics counters are built when CIC_CTRL_STATS_EN is defined.
module cic_dec_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int MAX_DEC_FACTOR = 16,
  parameter int DEC_WIDTH      = $clog2(MAX_DEC_FACTOR),
  parameter int Q              = 1,
  parameter int N              = 1,
  parameter int RESET_DEC      = 1,
  parameter int DRAIN_CYCLES   = 4,
  parameter int FLUSH_CYCLES   = 2,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  cic_dec_ctrl_if.slave         cfg,
  output logic                  busy,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  cic_valid_in,
  output logic [DATA_WIDTH-1:0] cic_in,
  output logic [DEC_WIDTH:0]    cic_dec_factor,
  output logic                  cic_rst_n,
  input  logic                  cic_valid_out,
  input  logic [DATA_WIDTH-1:0] cic_out,
  input  logic                  cic_overflow,
  input  logic                  cic_underflow,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  sat_flag,
  input  logic                  sat_clr,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic [CNT_WIDTH-1:0]  sat_cnt,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {FLUSH = 2'd0, SETTLE = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_t;

  localparam int DRAIN_LD_I  = DRAIN_CYCLES - 1;
  localparam int FLUSH_LD_I  = FLUSH_CYCLES - 1;
  localparam int SETTLE_LD_I = Q * N;
  localparam int MAX_DF      = (DRAIN_LD_I > FLUSH_LD_I) ? DRAIN_LD_I : FLUSH_LD_I;
  localparam int CNT_MAX     = (MAX_DF > SETTLE_LD_I) ? MAX_DF : SETTLE_LD_I;
  localparam int CW          = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]        DRAIN_LD  = CW'(DRAIN_LD_I);
  localparam logic [CW-1:0]        FLUSH_LD  = CW'(FLUSH_LD_I);
  localparam logic [CW-1:0]        SETTLE_LD = CW'(SETTLE_LD_I);
  localparam logic [CW-1:0]        CNT_ONE   = CW'(1);
  localparam logic [DEC_WIDTH:0]   DEC_ONE   = (DEC_WIDTH+1)'(1);
  localparam logic [DEC_WIDTH:0]   DEC_RST   = (DEC_WIDTH+1)'(RESET_DEC);

  state_t               state, state_nx;
  logic [CW-1:0]        cnt, cnt_nx;
  logic [DEC_WIDTH:0]   dec_q, dec_nx, pend_q, pend_nx;
  logic                 err_q, err_nx;
  logic                 rst_n_q;
  logic                 pass;
  logic                 sat_hit;

  // Legal factors are the powers of two up to MAX_DEC_FACTOR.
  function automatic logic is_legal(input logic [DEC_WIDTH:0] d);
    return (d != '0) && ((d & (d - DEC_ONE)) == '0) && (int'(d) <= MAX_DEC_FACTOR);
  endfunction

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    dec_nx   = dec_q;
    pend_nx  = pend_q;
    err_nx   = 1'b0;
    case (state)
      RUN: begin
        if (cfg.cfg_valid) begin
          if (!is_legal(cfg.cfg_dec)) begin
            err_nx = 1'b1;
          end else if (cfg.cfg_dec != dec_q) begin
            pend_nx  = cfg.cfg_dec;
            cnt_nx   = DRAIN_LD;
            state_nx = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (cnt == '0) begin
          dec_nx   = pend_q;
          cnt_nx   = FLUSH_LD;
          state_nx = FLUSH;
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      FLUSH: begin
        if (cnt == '0) begin
          cnt_nx   = SETTLE_LD;
          state_nx = SETTLE;
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      SETTLE: begin
        // Outputs emerging after a flush are masked until Q*N of them have passed.
        if (cic_valid_out) begin
          if (cnt == '0) state_nx = RUN;
          else           cnt_nx   = cnt - CNT_ONE;
        end
      end
      default: state_nx = FLUSH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FLUSH;
      cnt      <= FLUSH_LD;
      dec_q    <= DEC_RST;
      pend_q   <= DEC_RST;
      err_q    <= 1'b0;
      rst_n_q  <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      dec_q   <= dec_nx;
      pend_q  <= pend_nx;
      err_q   <= err_nx;
      // Decoded from next state so the flush strobe toggles with the state register.
      rst_n_q <= (state_nx != FLUSH);
      if (sat_hit)      sat_flag <= 1'b1;
      else if (sat_clr) sat_flag <= 1'b0;
    end
  end

  assign pass           = (state == RUN) || (state == SETTLE);
  assign cic_valid_in   = in_valid & pass;
  assign cic_in         = in_data;
  assign cic_dec_factor = dec_q;
  assign cic_rst_n      = rst_n_q;
  assign cfg.cfg_ready  = (state == RUN);
  assign cfg.cfg_err    = err_q;
  assign busy           = (state != RUN);
  assign out_valid      = cic_valid_out & ((state == RUN) || (state == DRAIN) ||
                                           ((state == SETTLE) && (cnt == '0)));
  assign out_data       = cic_out;
  assign sat_hit        = out_valid & (cic_overflow | cic_underflow);
  assign dbg_state      = state;

`ifdef CIC_CTRL_STATS_EN
  localparam logic [CNT_WIDTH-1:0] STAT_ONE = CNT_WIDTH'(1);
  logic [CNT_WIDTH-1:0] drop_q, satc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= '0;
      satc_q <= '0;
    end else begin
      if (in_valid && !pass && (drop_q != '1)) drop_q <= drop_q + STAT_ONE;
      // A saturated output coinciding with the clear is counted after clearing.
      if (sat_clr)                         satc_q <= sat_hit ? STAT_ONE : '0;
      else if (sat_hit && (satc_q != '1))  satc_q <= satc_q + STAT_ONE;
    end
  end

  assign drop_cnt = drop_q;
  assign sat_cnt  = satc_q;
`else
  assign drop_cnt = '0;
  assign sat_cnt  = '0;
`endif

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// Bench for cic_dec_ctrl: directed reconfiguration scenarios plus random traffic against a timeline model.
module tb_cic_dec_ctrl;
  localparam int DW      = 16;
  localparam int DEC_W   = 4;
  localparam int MAXD    = 16;
  localparam int DRAIN   = 4;
  localparam int FLUSH   = 2;
  localparam int QN      = 1;
  localparam int RST_DEC = 1;
  localparam int CW      = 16;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, cic_valid_out, cic_overflow, cic_underflow, sat_clr;
  logic [DW-1:0] in_data, cic_out;
  logic busy, cic_valid_in, cic_rst_n, out_valid, sat_flag;
  logic [DW-1:0] cic_in, out_data;
  logic [DEC_W:0] cic_dec_factor;
  logic [CW-1:0] drop_cnt, sat_cnt;
  logic [1:0] dbg_state;

  cic_dec_ctrl_if #(.DEC_WIDTH(DEC_W)) cfg_bus ();

  cic_dec_ctrl dut (
    .clk(clk), .rst(rst), .cfg(cfg_bus.slave), .busy(busy),
    .in_valid(in_valid), .in_data(in_data),
    .cic_valid_in(cic_valid_in), .cic_in(cic_in), .cic_dec_factor(cic_dec_factor), .cic_rst_n(cic_rst_n),
    .cic_valid_out(cic_valid_out), .cic_out(cic_out), .cic_overflow(cic_overflow), .cic_underflow(cic_underflow),
    .out_valid(out_valid), .out_data(out_data), .sat_flag(sat_flag), .sat_clr(sat_clr),
    .drop_cnt(drop_cnt), .sat_cnt(sat_cnt), .dbg_state(dbg_state)
  );

  // Clock and cycle tag
  always #5 clk = ~clk;
  logic [15:0] cyc = 16'd0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // Reference model: a reconfiguration is a timeline counted from the accepting edge.
  // k in [0,DRAIN) drains, k in [DRAIN,DRAIN+FLUSH) flushes, then QN outputs settle.
  int             m_k;
  logic [DEC_W:0] m_dec, m_pend;
  logic           m_settling;
  int             m_left;
  logic           m_err, m_sat;
  int             m_drop, m_satc;
  logic e_pass, e_ov, e_busy, e_flush;

  function automatic logic legal(input logic [DEC_W:0] d);
    logic ok = 1'b0;
    for (int p = 1; p <= MAXD; p = p * 2) if (int'(d) == p) ok = 1'b1;
    return ok;
  endfunction

  task automatic model_reset();
    m_k = DRAIN; m_dec = (DEC_W+1)'(RST_DEC); m_pend = (DEC_W+1)'(RST_DEC);
    m_settling = 1'b0; m_left = 0; m_err = 1'b0; m_sat = 1'b0; m_drop = 0; m_satc = 0;
  endtask

  task automatic predict();
    e_flush = (m_k >= DRAIN);
    e_pass  = (m_k < 0);
    e_busy  = (m_k >= 0) || m_settling;
    e_ov    = cic_valid_out && !e_flush && !(e_pass && m_settling && m_left > 0);
  endtask

  task automatic advance();
    logic hit;
    hit = e_ov && (cic_overflow || cic_underflow);
    if (hit) m_sat = 1'b1;
    else if (sat_clr) m_sat = 1'b0;
    if (in_valid && !e_pass && m_drop < 65535) m_drop++;
    if (sat_clr) m_satc = hit ? 1 : 0;
    else if (hit && m_satc < 65535) m_satc++;
    m_err = 1'b0;
    if (m_k >= 0) begin
      m_k++;
      if (m_k == DRAIN) m_dec = m_pend;
      if (m_k == DRAIN + FLUSH) begin m_k = -1; m_settling = 1'b1; m_left = QN; end
    end else if (m_settling) begin
      if (cic_valid_out) begin
        if (m_left == 0) m_settling = 1'b0;
        else m_left--;
      end
    end else if (cfg_bus.cfg_valid) begin
      if (!legal(cfg_bus.cfg_dec)) m_err = 1'b1;
      else if (cfg_bus.cfg_dec != m_dec) begin m_pend = cfg_bus.cfg_dec; m_k = 0; end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver: one clock cycle of stimulus, expectations pushed before the DUT responds.
  task automatic step(input logic r, input logic iv, input logic cv, input logic ov, input logic ud,
                      input logic clr, input logic cfgv, input logic [DEC_W:0] cd);
    rst = r; in_valid = iv; in_data = DW'($urandom); cic_valid_out = cv; cic_out = DW'($urandom);
    cic_overflow = ov; cic_underflow = ud; sat_clr = clr;
    cfg_bus.cfg_valid = cfgv; cfg_bus.cfg_dec = cd;
    if (r) model_reset();
    predict();
    if (e_ov) exp_q.push_back({cyc, cic_out});
    @(negedge clk);
    chk("cic_valid_in", 32'(cic_valid_in), 32'(in_valid && e_pass));
    chk("cic_in", 32'(cic_in), 32'(in_data));
    chk("cic_dec_factor", 32'(cic_dec_factor), 32'(m_dec));
    chk("cic_rst_n", 32'(cic_rst_n), 32'(!e_flush));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("cfg_ready", 32'(cfg_bus.cfg_ready), 32'(!e_busy));
    chk("cfg_err", 32'(cfg_bus.cfg_err), 32'(m_err));
    chk("sat_flag", 32'(sat_flag), 32'(m_sat));
`ifdef CIC_CTRL_STATS_EN
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    chk("sat_cnt", 32'(sat_cnt), 32'(m_satc));
`else
    chk("drop_cnt", 32'(drop_cnt), 32'd0);
    chk("sat_cnt", 32'(sat_cnt), 32'd0);
`endif
    @(posedge clk);
    if (!r) advance();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic run_until_idle(input int max_cyc);
    int n = 0;
    while ((m_k >= 0 || m_settling) && n < max_cyc) begin
      step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0, '0);
      n++;
    end
    checks++;
    if (m_k >= 0 || m_settling) begin
      errors++;
      $display("FAIL settle_timeout: still reconfiguring after %0d cycles, expected idle", n);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [31:0] e;
    if (out_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_valid: got output %0h at cycle %0d, expected none", out_data, cyc);
      end else begin
        e = exp_q.pop_front();
        if ({cyc, out_data} !== e) begin
          errors++;
          $display("FAIL out_data: got cycle %0d data %0h, expected cycle %0d data %0h",
                   cyc, out_data, e[31:16], e[15:0]);
        end
      end
    end
  end

  logic [DEC_W:0] dec_tab [10] = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16, 5'd0, 5'd3, 5'd6, 5'd17, 5'd31};

  initial begin
    cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_dec = '0;
    // Reset, then first settle with continuous input
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    run_until_idle(40);
    idle(3);
    // Legal change to 8
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8);
    run_until_idle(40);
    idle(2);
    // Illegal requests
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6);  idle(2);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);  idle(2);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd17); idle(2);
    // Change to 4, then repeat 4
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4);
    run_until_idle(40);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4);
    idle(6);
    // Saturation flag and counter
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    idle(2);
    // Reset during DRAIN, then a clean change
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd16);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    run_until_idle(40);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2);
    run_until_idle(40);
    // Random traffic
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 5) == 0), dec_tab[$urandom_range(0, 9)]);
    end
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL exp_q_drain: %0d expected outputs never appeared, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cic_dec_ctrl.md
Name: cic_dec_ctrl

Overview:
- Run-time controller for the CIC decimator.
- Accepts decimation-factor change requests over a valid/ready handshake and checks them for legality.
- Sequences each change through a safe reconfiguration: drain the pipeline, flush it with a reset pulse, then suppress settling outputs before streaming resumes.
- Sits between the upstream sample source and the CIC instance. It gates the CIC's valid_in, drives its dec_factor and rst_n, and qualifies its output valid.

Parameters:
- DATA_WIDTH, 16, sample width passed through to and from the CIC.
- MAX_DEC_FACTOR, 16, largest legal decimation factor. Legal set is {1,2,4,8,16}, limited to values ≤ MAX_DEC_FACTOR.
- DEC_WIDTH, $clog2(MAX_DEC_FACTOR), dec_factor bus is DEC_WIDTH+1 bits.
- Q, 1, CIC order, used for the settle count.
- N, 1, CIC differential delay, used for the settle count.
- RESET_DEC, 1, decimation factor loaded at reset. Must be legal.
- DRAIN_CYCLES, 4, clock cycles spent in DRAIN (≥ CIC input-to-output latency).
- FLUSH_CYCLES, 2, clock cycles cic_rst_n is held low in FLUSH (≥1).
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- cfg_valid  in  1  decimation-change request valid
- cfg_dec  in  DEC_WIDTH+1  requested decimation factor
- cfg_ready  out  1  controller can accept a request
- cfg_err  out  1  one-cycle pulse: request rejected as illegal
- busy  out  1  high in any state other than RUN
- in_valid  in  1  upstream sample valid (free-running, no backpressure)
- in_data  in  DATA_WIDTH  upstream sample
- cic_valid_in  out  1  to CIC valid_in
- cic_in  out  DATA_WIDTH  to CIC cic_in (= in_data)
- cic_dec_factor  out  DEC_WIDTH+1  to CIC dec_factor
- cic_rst_n  out  1  to CIC rst_n, active-low flush
- cic_valid_out  in  1  from CIC valid_out
- cic_out  in  DATA_WIDTH  from CIC cic_out
- cic_overflow  in  1  from CIC overflow
- cic_underflow  in  1  from CIC underflow
- out_valid  out  1  qualified output valid
- out_data  out  DATA_WIDTH  = cic_out
- sat_flag  out  1  sticky: overflow or underflow seen on a qualified output
- sat_clr  in  1  clears sat_flag
- drop_cnt  out  CNT_WIDTH  samples dropped while gated (feature-dependent)
- sat_cnt  out  CNT_WIDTH  qualified saturated outputs (feature-dependent)

Behaviour:
- FSM states: FLUSH, SETTLE, RUN, DRAIN. One down-counter is shared by the timed states.
- Reset (async, rst=1): state=FLUSH, counter=FLUSH_CYCLES-1, cic_dec_factor=RESET_DEC, cic_rst_n=0 (combinational from rst), cfg_ready=0, cfg_err=0, busy=1, out_valid=0, sat_flag=0, counters=0.
- Gate: pass = (state==RUN || state==SETTLE). cic_valid_in = in_valid & pass, combinational, zero latency. cic_in = in_data always.
- RUN:
  - cfg_ready=1.
  - On cfg_valid & cfg_ready:
    - cfg_dec illegal (not a power of two, zero, or >MAX_DEC_FACTOR): cfg_err=1 on the next cycle only; stay in RUN.
    - cfg_dec == current factor: accept, no action.
    - Otherwise: latch pending=cfg_dec, load counter=DRAIN_CYCLES-1, go to DRAIN.
- DRAIN:
  - cfg_ready=0, pass=0.
  - CIC outputs still emerging are qualified normally (out_valid follows cic_valid_out).
  - At counter==0: cic_dec_factor<=pending, counter<=FLUSH_CYCLES-1, go to FLUSH.
- FLUSH:
  - cic_rst_n=0, pass=0, out_valid=0.
  - At counter==0: counter<=Q*N, go to SETTLE.
- SETTLE:
  - cic_rst_n=1, pass=1.
  - Each cic_valid_out decrements the counter and is masked (out_valid=0).
  - When cic_valid_out arrives with counter==0, it is qualified and the state goes to RUN.
- out_valid = cic_valid_out & (state==RUN || state==DRAIN || (state==SETTLE && counter==0)). Combinational.
- sat_flag: set when out_valid & (cic_overflow|cic_underflow). Cleared by sat_clr. If set and clear occur in the same cycle, set wins.
- cic_rst_n is low whenever rst=1 or state==FLUSH. It is registered-decoded from state, with no glitch on state change.
- A cfg_valid arriving while busy is not accepted (cfg_ready=0). The requester must hold it until ready.
- rst asserted mid-sequence: abandon any pending request and return to the reset values above.

Optional Feature:
- Macro CIC_CTRL_STATS_EN.
- Defined:
  - drop_cnt increments on in_valid & !pass.
  - sat_cnt increments on out_valid & (cic_overflow|cic_underflow).
  - Both saturate at all-ones. Both clear on rst. sat_clr also clears sat_cnt.
- Undefined: drop_cnt and sat_cnt are tied to 0 and no counter logic is built.

Test Plan:
- Reset: release rst, in_valid=1 every cycle → cic_rst_n low for 2 cycles after release; busy=1 until first qualified output; cic_dec_factor=1; with Q=N=1 the first CIC output is masked and the second is qualified.
- Legal change in RUN: cfg_dec=8 pulse → cfg_ready drops the next cycle; cic_valid_in=0 for 4 DRAIN + 2 FLUSH cycles; cic_dec_factor=8 at FLUSH entry; cic_rst_n low exactly 2 cycles; busy clears after the first qualified output.
- Illegal request: cfg_dec=6, then cfg_dec=0, then cfg_dec=17 → cfg_err single-cycle pulse each time; state stays RUN; cic_dec_factor unchanged.
- Same-factor request: cfg_dec=current (4) → accepted; no DRAIN; cic_valid_in never drops.
- Saturation: force cic_overflow=1 with cic_valid_out in RUN → sat_flag=1 and sat_cnt=1 (stats on); sat_clr and overflow in the same cycle → sat_flag stays 1; sat_clr alone → sat_flag=0, sat_cnt=0.
- Reset mid-DRAIN: request 16, assert rst on the 2nd DRAIN cycle → cic_dec_factor=RESET_DEC (1) and state=FLUSH; drop_cnt=0 after reset; drop_cnt counts 6 gated samples in a subsequent clean change (stats on).
